// File: rtl/alu_arbiter.sv
// Two-port arbiter/sequencer for the shared ALU: registered operand drive, 2-cycle done.
// Optional macro ALU_ARB_RR_EN selects round-robin arbitration (fixed priority otherwise).
module alu_arbiter #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic [DATA_W-1:0] i_l0,
    input  logic [DATA_W-1:0] i_r0,
    input  logic [DATA_W-1:0] i_l1,
    input  logic [DATA_W-1:0] i_r1,
    input  logic [OP_W-1:0]   i_op0,
    input  logic [OP_W-1:0]   i_op1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic              o_done0,
    output logic              o_done1,
    output logic [DATA_W-1:0] o_res,
    output logic [3:0]        o_flags,
    output logic [DATA_W-1:0] o_alu_l,
    output logic [DATA_W-1:0] o_alu_r,
    output logic [OP_W-1:0]   o_alu_op,
    input  logic [DATA_W-1:0] i_alu_res,
    input  logic [3:0]        i_alu_flags
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_reg, state_next;
    logic   owner_reg;
    logic   req_any;
    logic   grant_port;
    logic   accept;

    assign req_any = i_req0 | i_req1;

`ifdef ALU_ARB_RR_EN
    // Remembers the last granted port; starts at 1 so port 0 wins the first tie.
    logic last_reg;

    assign grant_port = (i_req0 && i_req1) ? ~last_reg : i_req1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_reg <= 1'b1;
        end else if (accept) begin
            last_reg <= grant_port;
        end
    end
`else
    assign grant_port = ~i_req0;
`endif

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_any) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                // Back-to-back acceptance on the same edge the result is returned.
                if (req_any) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            o_ack0    <= 1'b0;
            o_ack1    <= 1'b0;
            o_done0   <= 1'b0;
            o_done1   <= 1'b0;
            o_res     <= '0;
            o_flags   <= '0;
            o_alu_l   <= '0;
            o_alu_r   <= '0;
            o_alu_op  <= '0;
        end else begin
            state_reg <= state_next;
            o_ack0    <= accept && !grant_port;
            o_ack1    <= accept && grant_port;
            o_done0   <= (state_reg == RESP) && !owner_reg;
            o_done1   <= (state_reg == RESP) && owner_reg;
            if (accept) begin
                owner_reg <= grant_port;
                o_alu_l   <= grant_port ? i_l1  : i_l0;
                o_alu_r   <= grant_port ? i_r1  : i_r0;
                o_alu_op  <= grant_port ? i_op1 : i_op0;
            end
            if (state_reg == RESP) begin
                o_res   <= i_alu_res;
                o_flags <= i_alu_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a registered model ALU; flags = {zero, neg, carry, ovf}.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] l0 = '0, r0 = '0, l1 = '0, r1 = '0;
    logic [2:0] op0 = '0, op1 = '0;
    logic       ack0, ack1, done0, done1;
    logic [7:0] res, alu_l, alu_r;
    logic [3:0] flags;
    logic [2:0] alu_op;
    logic [7:0] alu_res = '0;
    logic [3:0] alu_flags = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(8), .OP_W(3)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(req0), .i_req1(req1),
        .i_l0(l0), .i_r0(r0), .i_l1(l1), .i_r1(r1),
        .i_op0(op0), .i_op1(op1),
        .o_ack0(ack0), .o_ack1(ack1), .o_done0(done0), .o_done1(done1),
        .o_res(res), .o_flags(flags),
        .o_alu_l(alu_l), .o_alu_r(alu_r), .o_alu_op(alu_op),
        .i_alu_res(alu_res), .i_alu_flags(alu_flags)
    );

    // Model ALU with one cycle of registered latency.
    function automatic logic [11:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] y;
        logic       c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                y = s[7:0];
                c = s[8];
                v = (a[7] == b[7]) && (y[7] != a[7]);
            end
            3'd1: y = a & b;
            3'd2: y = a | b;
            3'd3: y = a ^ b;
            default: y = 8'h00;
        endcase
        return {(y == 8'h00), y[7], c, v, y};
    endfunction

    always @(posedge clk) {alu_flags, alu_res} <= alu_f(alu_op, alu_l, alu_r);

    always @(posedge clk) begin
        #2;
        if (done0 || done1)
            $display("op done port=%0d res=%h flags=%h", done1 ? 1 : 0, res, flags);
    end

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [1:0] ack_vec(input logic p);
        return p ? 2'b01 : 2'b10;
    endfunction

    logic [4:0] g_seq;
    logic       gp, gn;

    initial begin
        // Reset state
        rst_n = 1'b0;
        #2;
        check_value("reset_outputs",
            {ack0, ack1, done0, done1, res, flags, alu_l, alu_r, alu_op}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single port 0 ADD 0x7F + 0x01
        req0 = 1'b1; l0 = 8'h7F; r0 = 8'h01; op0 = 3'd0;
        tick();
        check_value("add_ack", {ack0, ack1}, 2'b10);
        check_value("add_alu_drive", {alu_l, alu_r, alu_op}, {8'h7F, 8'h01, 3'd0});
        req0 = 1'b0;
        tick();
        check_value("add_exec_quiet", {ack0, ack1, done0, done1}, 4'b0000);
        tick();
        check_value("add_done", {done0, done1}, 2'b10);
        check_value("add_res", res, 8'h80);
        check_value("add_flags", flags, 4'b0101);
        tick();
        check_value("add_done_pulse", {ack0, ack1, done0, done1}, 4'b0000);

        // Idle hold for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            check_value("idle_hold",
                {ack0, ack1, done0, done1, res, flags, alu_l, alu_r, alu_op},
                {4'b0000, 8'h80, 4'b0101, 8'h7F, 8'h01, 3'd0});
        end

        // Simultaneous continuous requests
        do_reset();
`ifdef ALU_ARB_RR_EN
        g_seq = 5'b01010;
`else
        g_seq = 5'b00000;
`endif
        req0 = 1'b1; l0 = 8'hF0; r0 = 8'h3C; op0 = 3'd1;
        req1 = 1'b1; l1 = 8'h0F; r1 = 8'h30; op1 = 3'd2;
        tick();
        gp = g_seq[0];
        check_value("sim_first_ack", {ack0, ack1}, ack_vec(gp));
        check_value("sim_first_op", alu_op, gp ? 3'd2 : 3'd1);
        for (int i = 0; i < 4; i++) begin
            gp = g_seq[i];
            gn = g_seq[i+1];
            tick();
            check_value("sim_exec_quiet", {ack0, ack1, done0, done1}, 4'b0000);
            tick();
            check_value("sim_done", {done0, done1}, ack_vec(gp));
            check_value("sim_res", {flags, res}, {4'b0000, (gp ? 8'h3F : 8'h30)});
            check_value("sim_next_ack", {ack0, ack1}, ack_vec(gn));
            check_value("sim_next_op", alu_op, gn ? 3'd2 : 3'd1);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        gp = g_seq[4];
        tick();
        tick();
        check_value("sim_last_done", {done0, done1}, ack_vec(gp));
        check_value("sim_last_res", res, gp ? 8'h3F : 8'h30);
        tick();

        // Back-to-back on port 1: ADD 0x10+0x20, then XOR 0xAA^0xFF
        req1 = 1'b1; l1 = 8'h10; r1 = 8'h20; op1 = 3'd0;
        tick();
        check_value("b2b_ack1", {ack0, ack1}, 2'b01);
        op1 = 3'd3; l1 = 8'hAA; r1 = 8'hFF;
        tick();
        check_value("b2b_exec_no_ack", {ack0, ack1, done0, done1}, 4'b0000);
        tick();
        check_value("b2b_done1_ack1", {ack0, ack1, done0, done1}, 4'b0101);
        check_value("b2b_res1", res, 8'h30);
        check_value("b2b_op2", {alu_l, alu_r, alu_op}, {8'hAA, 8'hFF, 3'd3});
        req1 = 1'b0;
        tick();
        check_value("b2b_gap", {ack0, ack1, done0, done1}, 4'b0000);
        tick();
        check_value("b2b_done2", {ack0, ack1, done0, done1}, 4'b0001);
        check_value("b2b_res2", {flags, res}, {4'b0000, 8'h55});
        tick();

        // Request during EXEC: port 1 raises req one cycle after port 0 ack
        req0 = 1'b1; l0 = 8'h01; r0 = 8'h01; op0 = 3'd0;
        tick();
        check_value("exec_req_ack0", {ack0, ack1}, 2'b10);
        req0 = 1'b0;
        req1 = 1'b1; l1 = 8'hFF; r1 = 8'h0F; op1 = 3'd1;
        tick();
        check_value("exec_req_wait", {ack0, ack1, done0, done1}, 4'b0000);
        tick();
        check_value("exec_req_ack_done", {ack0, ack1, done0, done1}, 4'b0110);
        check_value("exec_req_res0", res, 8'h02);
        req1 = 1'b0;
        tick();
        tick();
        check_value("exec_req_done1", {done0, done1}, 2'b01);
        check_value("exec_req_res1", res, 8'h0F);
        tick();

        // Reset asserted during EXEC
        req0 = 1'b1; l0 = 8'h11; r0 = 8'h22; op0 = 3'd2;
        tick();
        check_value("rst_mid_ack", {ack0, ack1}, 2'b10);
        req0 = 1'b0;
        rst_n = 1'b0;
        #1;
        check_value("rst_mid_outputs",
            {ack0, ack1, done0, done1, res, flags, alu_l, alu_r, alu_op}, 64'd0);
        tick();
        tick();
        check_value("rst_mid_no_done", {done0, done1}, 2'b00);
        rst_n = 1'b1;
        tick();
        check_value("rst_after_no_done", {ack0, ack1, done0, done1}, 4'b0000);
        req0 = 1'b1; l0 = 8'h05; r0 = 8'h03; op0 = 3'd0;
        req1 = 1'b1; l1 = 8'h0F; r1 = 8'hF0; op1 = 3'd3;
        tick();
        check_value("rst_first_grant", {ack0, ack1}, 2'b10);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        check_value("rst_first_done", {done0, done1}, 2'b10);
        check_value("rst_first_res", res, 8'h08);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer for the shared 8-bit ALU. Accepts operation requests from the execute unit (port 0) and the address/increment unit (port 1), registers the winning operands onto the ALU inputs, waits out the ALU's one-cycle registered latency, and returns the result and flags to the granted requester with a done pulse. It sits between the requesters and the ALU instance; the ALU itself is outside this block.

## Interface

**Parameters**
- `DATA_W`, default 8: operand and result width.
- `OP_W`, default 3: ALU op code width.

**Ports**
- `i_clk`, input, 1: clock, rising edge.
- `i_rst_n`, input, 1: asynchronous active-low reset.
- `i_req0` / `i_req1`, input, 1: request from port 0 / port 1.
- `i_l0`, `i_r0` / `i_l1`, `i_r1`, input, DATA_W: left and right operands per port.
- `i_op0` / `i_op1`, input, OP_W: op per port (0 ADD, 1 AND, 2 OR, 3 XOR; 4–7 forwarded unchanged).
- `o_ack0` / `o_ack1`, output, 1: one-cycle accept pulse.
- `o_done0` / `o_done1`, output, 1: one-cycle result-valid pulse.
- `o_res`, output, DATA_W: result, shared by both ports.
- `o_flags`, output, 4: flags, shared by both ports.
- `o_alu_l`, `o_alu_r`, output, DATA_W: registered ALU operand drive.
- `o_alu_op`, output, OP_W: registered ALU op drive.
- `i_alu_res`, input, DATA_W: ALU result, registered inside the ALU.
- `i_alu_flags`, input, 4: ALU flags.

## Operation

- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE:** if any `i_reqN` is sampled high, select a winner. Latch its l/r/op into `o_alu_*`, assert the matching `o_ackN` for one cycle, record the owner, and go to EXEC. With no request, stay in IDLE; `o_alu_*` hold their values.
- **EXEC:** the ALU samples `o_alu_*` on this edge. Go to RESP. No acceptance in this state.
- **RESP:** capture `i_alu_res` into `o_res` and `i_alu_flags` into `o_flags`, and pulse `o_doneN` for the owner.
  - On the same edge, if a request is pending, accept it exactly as IDLE does and go to EXEC (back-to-back).
  - Otherwise go to IDLE.
- Arbitration when both ports request in the same cycle: see Configuration. A single requester always wins.
- Requester rules:
  - Hold `i_reqN` and operands stable until `o_ackN` is seen.
  - Deassert `i_reqN`, or present a new operation, in the cycle after ack at the latest.
  - A request still high two edges after ack is treated as a new request.
- `o_res` and `o_flags` hold their values until the next capture.
- The op code is passed through untouched; the arbiter performs no arithmetic.

## Timing

- Reset values: all outputs 0, state IDLE, round-robin pointer = 1 (port 0 wins first). Reset asserted mid-operation discards the in-flight op and no `o_done` is issued.
- Request sampled high at edge T (state IDLE):
  - `o_ackN` and `o_alu_*` are valid T..T+1.
  - The ALU computes at edge T+1.
  - `o_doneN`, `o_res` and `o_flags` are valid from T+2; `o_done` lasts one cycle.
- Latency from request to done is 2 cycles. Sustained throughput is one op per 2 cycles.
- At most one `o_ack` and at most one `o_done` are high in any cycle. `o_ack` for a new op and `o_done` for the previous op may coincide (RESP acceptance).
- A request arriving in EXEC waits; it is accepted at the RESP edge.

## Configuration

- `ALU_ARB_RR_EN` defined: round-robin.
  - Simultaneous requests are granted to the port not granted last.
  - The pointer updates on every grant.
- `ALU_ARB_RR_EN` undefined: fixed priority, port 0 always wins. The pointer register is not built.

## Test plan

- **Single port 0 ADD.** Reset, then `i_req0`=1, `i_l0`=0x7F, `i_r0`=0x01, `i_op0`=0 at edge T.
  - Expect `o_ack0` in T..T+1 and `o_alu_l`=0x7F, `o_alu_r`=0x01, `o_alu_op`=0.
  - Expect `o_done0` at T+2 with `o_res` = model ALU result 0x80, and `o_ack1`/`o_done1` never high.
- **Simultaneous requests.** Both ports request continuously with distinct ops (port 0 AND 0xF0&0x3C, port 1 OR 0x0F|0x30).
  - With `ALU_ARB_RR_EN`: grant order 0,1,0,1; results 0x30 / 0x3F on the matching `o_done`.
  - Without it: port 0 only, port 1 starved.
- **Back-to-back.** Port 1 presents a new XOR op (0xAA^0xFF) in the cycle after its first ack.
  - Expect its second ack coincident with the first `o_done1`.
  - Expect the second `o_done1` 2 cycles later with `o_res`=0x55.
- **Request during EXEC.** Port 1 raises req one cycle after port 0 is acked.
  - Expect `o_ack1` to coincide with `o_done0`, not earlier.
- **Reset mid-op.** Assert `i_rst_n`=0 in EXEC.
  - Expect all outputs 0 immediately and no `o_done`.
  - After release, the first simultaneous request goes to port 0.
- **Idle hold.** After one op, keep both reqs low for 10 cycles.
  - Expect `o_res`, `o_flags` and `o_alu_*` unchanged and no ack/done pulses.
